// File: rtl/eeprom_reader_pkg.sv
// rtl/eeprom_reader_pkg.sv - shared constants and state type for the EEPROM readback engine
//
// Purpose: EEPROM geometry constants and the reader_t state enumeration.
// Optional feature macro: READER_CKSUM_EN adds the CKSUM state.
// Ports: none (package).
package eeprom_reader_pkg;

  localparam int EEPROM_ADDR_W = 17;
  localparam int EEPROM_DATA_W = 8;
  localparam logic [EEPROM_ADDR_W-1:0] EEPROM_LAST_ADDR = 17'h1FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    PUSH,
    NEXT,
`ifdef READER_CKSUM_EN
    CKSUM,
`endif
    DONE
  } reader_t;

endpackage

// File: rtl/eeprom_acc_timer.sv
// rtl/eeprom_acc_timer.sv - load/count/expire counter that times the EEPROM access window
//
// Purpose: counts the cycles nce/noe are held before data capture.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   load    in  restart the count at zero
//   en      in  advance the count
//   expired out count has reached T_ACC_CYC-1 (this is the last access cycle)
module eeprom_acc_timer #(
  parameter int T_ACC_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (T_ACC_CYC > 1) ? $clog2(T_ACC_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(T_ACC_CYC - 1);

  logic [CW-1:0] acc_cnt;

  // Saturates at LAST_CNT so the counter never needs a spare bit.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      acc_cnt <= '0;
    end else if (en && !expired) begin
      acc_cnt <= acc_cnt + CW'(1);
    end
  end

  assign expired = (acc_cnt == LAST_CNT);

endmodule

// File: rtl/eeprom_reader.sv
// rtl/eeprom_reader.sv - EEPROM readback engine streaming an address range into the egress FIFO
//
// Purpose: reads rd_base..rd_last (inclusive) one byte at a time from the parallel
// EEPROM and writes each byte into the egress FIFO. Read only: nwe tied high.
// Optional feature macro: READER_CKSUM_EN appends a two's-complement checksum byte.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begin a read (sampled only in IDLE)
//   rd_base, rd_last     inclusive address range, latched with start
//   addr, data_in        EEPROM address / read data
//   nce, noe, nwe        EEPROM strobes, active low
//   full, din, wr_en     egress FIFO interface
//   busy, done           not-IDLE flag, one-cycle completion pulse
//   range_err            sticky: rd_last < rd_base at the last start
module eeprom_reader
  import eeprom_reader_pkg::*;
#(
  parameter int ADDR_W    = EEPROM_ADDR_W,
  parameter int DATA_W    = EEPROM_DATA_W,
  parameter int T_ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_last,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              nce,
  output logic              noe,
  output logic              nwe,
  input  logic              full,
  output logic [DATA_W-1:0] din,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  reader_t           state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;
  logic [DATA_W-1:0] byte_q;
  logic              timer_load;
  logic              timer_en;
  logic              timer_expired;
`ifdef READER_CKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign nwe        = 1'b1;
  assign timer_load = (state == SETUP);
  assign timer_en   = (state == ACCESS);

  eeprom_acc_timer #(
    .T_ACC_CYC(T_ACC_CYC)
  ) u_acc_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      nce       <= 1'b1;
      noe       <= 1'b1;
      din       <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
      cur       <= '0;
      last      <= '0;
      byte_q    <= '0;
`ifdef READER_CKSUM_EN
      sum       <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (rd_last >= rd_base) begin
              range_err <= 1'b0;
              cur       <= rd_base;
              last      <= rd_last;
`ifdef READER_CKSUM_EN
              sum       <= '0;
`endif
              state     <= SETUP;
            end else begin
              // Bad range: report and finish without touching the EEPROM.
              range_err <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SETUP: begin
          addr  <= cur;
          nce   <= 1'b0;
          noe   <= 1'b0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (timer_expired) state <= CAPTURE;
        end
        CAPTURE: begin
          byte_q <= data_in;
          nce    <= 1'b1;
          noe    <= 1'b1;
          state  <= PUSH;
        end
        PUSH: begin
          // Only writer of the FIFO, so full sampled here stays valid for the write.
          if (!full) begin
            din   <= byte_q;
            wr_en <= 1'b1;
`ifdef READER_CKSUM_EN
            sum   <= sum + byte_q;
`endif
            state <= NEXT;
          end
        end
        NEXT: begin
          // Terminal compare before increment keeps cur from wrapping at the top address.
          if (cur == last) begin
`ifdef READER_CKSUM_EN
            state <= CKSUM;
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            cur   <= cur + ADDR_W'(1);
            state <= SETUP;
          end
        end
`ifdef READER_CKSUM_EN
        CKSUM: begin
          if (!full) begin
            din   <= ~sum + DATA_W'(1);
            wr_en <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
